// File: rtl/omok_btn_pkg.sv
// Shared constants and types for the OMOK push-button front end.
// The BTN_AUTOREPEAT_EN macro adds per-channel auto-repeat timers.
package omok_btn_pkg;

   localparam int NUM_BTN   = 6;
   localparam int BTN_LEFT  = 0;
   localparam int BTN_RIGHT = 1;
   localparam int BTN_UP    = 2;
   localparam int BTN_DOWN  = 3;
   localparam int BTN_PUT   = 4;
   localparam int BTN_UNDO  = 5;

   typedef logic [2:0] action_code_t;

   typedef enum logic [1:0] {
      S_LO = 2'd0,
      W_HI = 2'd1,
      S_HI = 2'd2,
      W_LO = 2'd3
   } db_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM and counter.
// With BTN_AUTOREPEAT_EN defined, a repeat timer re-pulses press while held.
module btn_debounce_ch
   import omok_btn_pkg::*;
#(
   parameter int DB_CYCLES     = 330000,
   parameter int CNT_W         = 19
`ifdef BTN_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY  = 16500000,
   parameter int REPEAT_PERIOD = 5000000,
   parameter bit REP_EN        = 1'b0
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic rel
);

   logic [1:0]       sync;
   logic             s;
   db_state_t        state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             level_nx, press_nx, rel_nx;
   logic             rpt_fire;

   assign s = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[0], btn_raw};
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RPT_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;
   logic [RPT_W-1:0] rpt;

   // Timer sits preloaded outside a steady hold, so leaving S_HI cancels it.
   assign rpt_fire = REP_EN && (state == S_HI) && s && (rpt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       rpt <= '0;
      else if (state != S_HI || !s)  rpt <= RPT_W'(REPEAT_DELAY - 1);
      else if (rpt == '0)            rpt <= RPT_W'(REPEAT_PERIOD - 1);
      else                           rpt <= rpt - 1'b1;
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      level_nx = level;
      press_nx = rpt_fire;
      rel_nx   = 1'b0;
      unique case (state)
         S_LO: if (s) begin
            state_nx = W_HI;
            cnt_nx   = CNT_W'(1);
         end
         W_HI: if (!s) begin
            state_nx = S_LO;
            cnt_nx   = '0;
         end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
            state_nx = S_HI;
            cnt_nx   = '0;
            level_nx = 1'b1;
            press_nx = 1'b1;
         end else begin
            cnt_nx   = cnt + 1'b1;
         end
         S_HI: if (!s) begin
            state_nx = W_LO;
            cnt_nx   = CNT_W'(1);
         end
         W_LO: if (s) begin
            state_nx = S_HI;
            cnt_nx   = '0;
         end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
            state_nx = S_LO;
            cnt_nx   = '0;
            level_nx = 1'b0;
            rel_nx   = 1'b1;
         end else begin
            cnt_nx   = cnt + 1'b1;
         end
         default: begin
            state_nx = S_LO;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_LO;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         level <= level_nx;
         press <= press_nx;
         rel   <= rel_nx;
      end
   end

endmodule

// File: rtl/omok_button_conditioner.sv
// Debounced button front end with a prioritised valid/ready action stream.
// BTN_AUTOREPEAT_EN enables auto-repeat on the REPEAT_MASK channels.
module omok_button_conditioner
   import omok_btn_pkg::*;
#(
   parameter int                 NUM_BTN       = omok_btn_pkg::NUM_BTN,
   parameter int                 DB_CYCLES     = 330000,
   parameter int                 CNT_W         = 19,
   parameter int                 REPEAT_DELAY  = 16500000,
   parameter int                 REPEAT_PERIOD = 5000000,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK   = NUM_BTN'(6'b001111)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               action_valid,
   output action_code_t       action_code,
   input  logic               action_ready,
   output logic               overflow
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DB_CYCLES     (DB_CYCLES),
         .CNT_W         (CNT_W)
`ifdef BTN_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .REP_EN        (REPEAT_MASK[i])
`endif
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .btn_raw (btn_raw[i]),
         .level   (btn_level[i]),
         .press   (btn_press[i]),
         .rel     (btn_release[i])
      );
   end

   logic [NUM_BTN-1:0] pending, pending_nx;
   logic [NUM_BTN-1:0] cand, pick, clr, hold, drop;
   action_code_t       pick_code;
   logic               load;

   // A press arriving this cycle is a load candidate too, so an idle queue
   // presents it on the very next cycle.
   always_comb begin
      cand      = pending | btn_press;
      pick      = '0;
      pick_code = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (cand[i]) begin
            pick      = '0;
            pick[i]   = 1'b1;
            pick_code = action_code_t'(i);
         end
      end
      load = !action_valid && (cand != '0);
      clr  = load ? pick : '0;
      for (int i = 0; i < NUM_BTN; i++)
         hold[i] = action_valid && !action_ready && (action_code == action_code_t'(i));
      // A bit being loaded out this cycle frees its slot, so a press landing
      // on it re-sets pending instead of overflowing.
      drop       = btn_press & ((pending & ~clr) | hold);
      pending_nx = (pending & ~clr) | (btn_press & ~drop & (pending | ~clr));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending      <= '0;
         action_valid <= 1'b0;
         action_code  <= '0;
         overflow     <= 1'b0;
      end else begin
         pending  <= pending_nx;
         overflow <= overflow | (|drop);
         if (action_valid && action_ready) begin
            action_valid <= 1'b0;
         end else if (load) begin
            action_valid <= 1'b1;
            action_code  <= pick_code;
         end
      end
   end

endmodule

// File: tb/tb_omok_button_conditioner.sv
// Directed bench for omok_button_conditioner (DB_CYCLES=4); define
// BTN_AUTOREPEAT_EN in both RTL and bench to exercise auto-repeat.
module tb_omok_button_conditioner;
   import omok_btn_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [5:0]   btn_raw;
   logic [5:0]   btn_level, btn_press, btn_release;
   logic         action_valid;
   action_code_t action_code;
   logic         action_ready;
   logic         overflow;

   int n_cmp = 0;
   int n_bad = 0;

   omok_button_conditioner #(
      .NUM_BTN       (6),
      .DB_CYCLES     (4),
      .CNT_W         (4),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (8),
      .REPEAT_MASK   (6'b001111)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .btn_press    (btn_press),
      .btn_release  (btn_release),
      .action_valid (action_valid),
      .action_code  (action_code),
      .action_ready (action_ready),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_raw = '0; action_ready = 1'b0;
      #1;
      n_cmp++; if ({btn_level, btn_press, btn_release} !== 18'd0) begin
         n_bad++; $display("FAIL reset_levels: got %b required 0", {btn_level, btn_press, btn_release});
      end
      n_cmp++; if ({action_valid, action_code, overflow} !== 5'd0) begin
         n_bad++; $display("FAIL reset_action: valid=%b code=%0d ovf=%b required 0/0/0", action_valid, action_code, overflow);
      end
      settle(2);
      rst = 1'b0;
      settle(2);
      n_cmp++; if ({btn_level, btn_press, action_valid} !== 13'd0) begin
         n_bad++; $display("FAIL reset_idle: level=%b press=%b valid=%b required 0", btn_level, btn_press, action_valid);
      end
   endtask

   task automatic test_clean_press();
      btn_raw = 6'b000010;
      for (int k = 1; k <= 5; k++) begin
         step();
         n_cmp++; if (btn_press !== 6'b0 || btn_level !== 6'b0) begin
            n_bad++; $display("FAIL clean_early edge%0d: press=%b level=%b required 0/0", k, btn_press, btn_level);
         end
      end
      step();
      n_cmp++; if (btn_press !== 6'b000010 || btn_level !== 6'b000010) begin
         n_bad++; $display("FAIL clean_rise: press=%b level=%b required 000010/000010", btn_press, btn_level);
      end
      step();
      n_cmp++; if (btn_press !== 6'b0 || action_valid !== 1'b1 || action_code !== 3'd1) begin
         n_bad++; $display("FAIL clean_action: press=%b valid=%b code=%0d required 0/1/1", btn_press, action_valid, action_code);
      end
      action_ready = 1'b1;
      step();
      action_ready = 1'b0;
      n_cmp++; if (action_valid !== 1'b0) begin
         n_bad++; $display("FAIL clean_consume: valid=%b required 0", action_valid);
      end
      btn_raw = 6'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         n_cmp++; if (btn_release !== 6'b0 || btn_level !== 6'b000010) begin
            n_bad++; $display("FAIL release_early edge%0d: rel=%b level=%b required 0/000010", k, btn_release, btn_level);
         end
      end
      step();
      n_cmp++; if (btn_release !== 6'b000010 || btn_level !== 6'b0 || btn_press !== 6'b0) begin
         n_bad++; $display("FAIL release_fall: rel=%b level=%b press=%b required 000010/0/0", btn_release, btn_level, btn_press);
      end
      step();
      n_cmp++; if (btn_release !== 6'b0 || action_valid !== 1'b0) begin
         n_bad++; $display("FAIL release_after: rel=%b valid=%b required 0/0", btn_release, action_valid);
      end
   endtask

   task automatic test_bounce();
      logic [4:0] pat;
      pat = 5'b10101;
      for (int k = 4; k >= 0; k--) begin
         btn_raw = {1'b0, pat[k], 4'b0};
         step();
         n_cmp++; if (btn_press !== 6'b0) begin
            n_bad++; $display("FAIL bounce_quiet sample%0d: press=%b required 0", 4 - k, btn_press);
         end
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         n_cmp++; if (btn_press !== 6'b0 || btn_level !== 6'b0) begin
            n_bad++; $display("FAIL bounce_wait edge%0d: press=%b level=%b required 0/0", k, btn_press, btn_level);
         end
      end
      step();
      n_cmp++; if (btn_press !== 6'b010000) begin
         n_bad++; $display("FAIL bounce_press: press=%b required 010000", btn_press);
      end
      step();
      n_cmp++; if (btn_press !== 6'b0 || action_valid !== 1'b1 || action_code !== 3'd4) begin
         n_bad++; $display("FAIL bounce_action: press=%b valid=%b code=%0d required 0/1/4", btn_press, action_valid, action_code);
      end
      action_ready = 1'b1;
      step();
      action_ready = 1'b0;
      btn_raw = 6'b0;
      settle(8);
   endtask

   task automatic test_simultaneous();
      bit ev[9] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
      int ec[9] = '{0, 0, 3, 0, 5, 0, 0, 0, 0};
      action_ready = 1'b1;
      btn_raw = 6'b101001;
      settle(5);
      step();
      n_cmp++; if (btn_press !== 6'b101001) begin
         n_bad++; $display("FAIL simul_press: press=%b required 101001", btn_press);
      end
      for (int j = 0; j < 9; j++) begin
         step();
         n_cmp++; if (action_valid !== ev[j] || (ev[j] && action_code !== action_code_t'(ec[j]))) begin
            n_bad++; $display("FAIL simul_seq cycle%0d: valid=%b code=%0d required %b/%0d", j, action_valid, action_code, ev[j], ec[j]);
         end
      end
      n_cmp++; if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL simul_ovf: overflow=%b required 0", overflow);
      end
      action_ready = 1'b0;
      btn_raw = 6'b0;
      settle(8);
   endtask

   task automatic test_backpressure();
      int extra;
      action_ready = 1'b0;
      btn_raw = 6'b000100;
      settle(6);
      step();
      n_cmp++; if (action_valid !== 1'b1 || action_code !== 3'd2) begin
         n_bad++; $display("FAIL bp_first: valid=%b code=%0d required 1/2", action_valid, action_code);
      end
      btn_raw = 6'b0;
      settle(8);
      btn_raw = 6'b000100;
      settle(6);
      n_cmp++; if (btn_press !== 6'b000100 || overflow !== 1'b0) begin
         n_bad++; $display("FAIL bp_second_press: press=%b ovf=%b required 000100/0", btn_press, overflow);
      end
      step();
      n_cmp++; if (overflow !== 1'b1 || action_valid !== 1'b1 || action_code !== 3'd2) begin
         n_bad++; $display("FAIL bp_overflow: ovf=%b valid=%b code=%0d required 1/1/2", overflow, action_valid, action_code);
      end
      action_ready = 1'b1;
      step();
      n_cmp++; if (action_valid !== 1'b0) begin
         n_bad++; $display("FAIL bp_handshake: valid=%b required 0", action_valid);
      end
      extra = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (action_valid) extra++;
      end
      n_cmp++; if (extra !== 0 || overflow !== 1'b1) begin
         n_bad++; $display("FAIL bp_once: extra_valid_cycles=%0d ovf=%b required 0/1", extra, overflow);
      end
      action_ready = 1'b0;
      btn_raw = 6'b0;
      settle(8);
   endtask

   task automatic test_reset_mid();
      btn_raw = 6'b000001;
      settle(4);
      n_cmp++; if (btn_level !== 6'b0 || overflow !== 1'b1) begin
         n_bad++; $display("FAIL rmid_before: level=%b ovf=%b required 0/1", btn_level, overflow);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if ({btn_level, btn_press, btn_release, action_valid, action_code, overflow} !== 23'd0) begin
         n_bad++; $display("FAIL rmid_async: level=%b press=%b valid=%b code=%0d ovf=%b required all 0",
                           btn_level, btn_press, action_valid, action_code, overflow);
      end
      settle(2);
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         n_cmp++; if (btn_press !== 6'b0) begin
            n_bad++; $display("FAIL rmid_early edge%0d: press=%b required 0", k, btn_press);
         end
      end
      step();
      n_cmp++; if (btn_press !== 6'b000001) begin
         n_bad++; $display("FAIL rmid_press: press=%b required 000001", btn_press);
      end
      step();
      n_cmp++; if (action_valid !== 1'b1 || action_code !== 3'd0) begin
         n_bad++; $display("FAIL rmid_action: valid=%b code=%0d required 1/0", action_valid, action_code);
      end
      action_ready = 1'b1;
      step();
      action_ready = 1'b0;
      btn_raw = 6'b0;
      settle(8);
   endtask

   task automatic test_hold_repeat();
      int t2[$];
      int exp_t[$];
      int cnt4;
`ifdef BTN_AUTOREPEAT_EN
      exp_t.push_back(20);
      exp_t.push_back(28);
      exp_t.push_back(36);
`endif
      cnt4 = 0;
      action_ready = 1'b1;
      btn_raw = 6'b010100;
      settle(6);
      n_cmp++; if (btn_press !== 6'b010100) begin
         n_bad++; $display("FAIL hold_press: press=%b required 010100", btn_press);
      end
      for (int t = 1; t <= 40; t++) begin
         step();
         if (btn_press[2]) t2.push_back(t);
         if (btn_press[4]) cnt4++;
      end
      n_cmp++; if (t2.size() != exp_t.size()) begin
         n_bad++; $display("FAIL hold_repeat_count: ch2 extra presses=%0d required %0d", t2.size(), exp_t.size());
      end
      for (int k = 0; k < t2.size() && k < exp_t.size(); k++) begin
         n_cmp++; if (t2[k] != exp_t[k]) begin
            n_bad++; $display("FAIL hold_repeat_time%0d: at +%0d required +%0d", k, t2[k], exp_t[k]);
         end
      end
      n_cmp++; if (cnt4 != 0 || overflow !== 1'b0) begin
         n_bad++; $display("FAIL hold_put_norepeat: ch4 extra presses=%0d ovf=%b required 0/0", cnt4, overflow);
      end
      action_ready = 1'b0;
      btn_raw = 6'b0;
      settle(8);
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_backpressure();
      test_reset_mid();
      test_hold_repeat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/omok_button_conditioner.md
Name: omok_button_conditioner

Overview:
- Front-end stage directly upstream of the OMOK cursor/board logic.
- Takes raw, bouncing, asynchronous push-button levels (left, right, up, down, put, undo), then synchronises and debounces them.
- Produces clean levels and one-cycle press/release pulses.
- Serialises presses into a single prioritised action stream with a valid/ready handshake, so the downstream cursor/board logic handles exactly one action per accepted transfer and never loses simultaneous presses.

Parameters:
- NUM_BTN, 6, number of button channels. Index 0 left, 1 right, 2 up, 3 down, 4 put, 5 undo.
- DB_CYCLES, 330000, stable-sample count required to accept a level change (~10 ms at the 33 MHz LCD clock). Legal range 2..2^CNT_W-1.
- CNT_W, 19, debounce counter width.
- REPEAT_DELAY, 16500000, hold cycles before the first auto-repeat (only used with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between auto-repeats (only used with BTN_AUTOREPEAT_EN).
- REPEAT_MASK, 6'b001111, channels eligible for auto-repeat (directions only).

Ports:
- clk, input, 1, system/pixel clock.
- rst, input, 1, reset; asynchronous, active-high.
- btn_raw, input, NUM_BTN, raw button levels, asynchronous, 1 = pressed.
- btn_level, output, NUM_BTN, debounced level per channel.
- btn_press, output, NUM_BTN, one-cycle pulse on accepted 0->1.
- btn_release, output, NUM_BTN, one-cycle pulse on accepted 1->0.
- action_valid, output, 1, action_code is valid.
- action_code, output, 3, index of the button being delivered.
- action_ready, input, 1, consumer accepts the action this cycle.
- overflow, output, 1, sticky: a press arrived for a channel whose pending bit was already set.

Behaviour:
- Reset (asynchronous):
  - All synchroniser flops, counters, levels, pending bits and outputs go to 0.
  - action_code goes to 0 and overflow is cleared.
  - Reset asserted mid-debounce discards the partial count. After release, every channel starts in S_LO.
- Synchroniser:
  - Two flops per channel; s = second flop.
  - No other logic samples btn_raw.
- Per-channel FSM, with states S_LO, W_HI, S_HI, W_LO:
  - S_LO: s=1 -> W_HI, cnt<=1.
  - W_HI: s=0 -> S_LO, cnt<=0. Otherwise, if cnt==DB_CYCLES-1 -> S_HI, level<=1, press pulse. Otherwise cnt++.
  - S_HI and W_LO are symmetric, with a release pulse.
  - The counter never wraps; it saturates by the state change.
- Latency:
  - With btn_raw stable high from clock edge E0 (the first edge sampling 1), btn_level rises and btn_press pulses in the cycle after edge E0+1+DB_CYCLES.
  - All outputs are registered.
- Pulses: btn_press and btn_release are high for exactly one cycle and are never both high on the same channel.
- Pending queue:
  - pending[i] sets on btn_press[i].
  - When action_valid=0 and pending!=0, the lowest set index is loaded into action_code next cycle with action_valid=1, and that pending bit is cleared.
  - action_valid/action_code are held stable until action_ready=1. On handshake, the next pending item, if any, is presented the following cycle (one bubble cycle).
  - If a press sets a pending bit in the same cycle that bit is being cleared by a load, the set wins.
- Overflow: a press for channel i while pending[i]=1, or while action_valid=1 with action_code==i and no handshake that cycle, is dropped and sets overflow. overflow clears only on rst.
- Simultaneous presses: all are queued and delivered in ascending index order.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: for channels in REPEAT_MASK held in S_HI, an extra btn_press pulse (and pending set) is generated REPEAT_DELAY cycles after the original press, then every REPEAT_PERIOD cycles while still in S_HI. Leaving S_HI cancels the repeat timer immediately.
- Undefined: no repeat timers are synthesised, REPEAT_* parameters are ignored, and each hold yields exactly one press.

Decomposition:
- Package omok_btn_pkg holds:
  - NUM_BTN.
  - Index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_UP=2, BTN_DOWN=3, BTN_PUT=4, BTN_UNDO=5.
  - 3-bit action_code typedef.
  - Debounce FSM state encoding.
- Sub-module btn_debounce_ch contains the synchroniser, FSM and counter (plus the repeat timer when enabled) for one channel, instantiated NUM_BTN times.
- The top level holds only the pending queue, the handshake and the overflow logic.

Test Plan (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Clean press: btn_raw[1] 0->1 and held -> btn_press[1] single pulse and btn_level[1]=1 in the cycle after edge E0+5. action_valid=1, code=1 on the next cycle.
- Bounce: btn_raw[4] toggles 1,0,1,0 one cycle apart, then held high -> no press during the bounce. Exactly one press 5 edges after the final rising sample.
- Simultaneous: bits 0, 3 and 5 rise together, action_ready=1 -> codes delivered 0, 3, 5 in order, each separated by one bubble cycle; pending ends at 0.
- Backpressure/overflow: action_ready=0, press channel 2, release it, press it again -> code=2 stays held, overflow=1. Raising action_ready then delivers 2 exactly once.
- Reset mid-operation: assert rst with btn_raw[0] high and cnt=2 -> all outputs 0 immediately. After release, the press appears 5 edges after the first sampling edge.
- BTN_AUTOREPEAT_EN: hold btn_raw[2] -> initial press, then repeats at +20, +28, +36 cycles. A held btn_raw[4] produces no repeats.
